// File: rtl/csr_status_writer.sv
// Read-modify-write initiator for mstatus / mstatush / sstatus with a valid/ready request and response.
// Optional post-write readback of the register image is enabled by STATUS_WRITE_READBACK_EN.
module csr_status_writer #(
  parameter int XLEN        = 64,
  parameter int S_SUPPORTED = 1,
  parameter int U_SUPPORTED = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [1:0]      req_sel,
  input  logic [XLEN-1:0] req_operand,
  input  logic [1:0]      PrivilegeModeW,
  input  logic            StallW,
  input  logic            TrapM,
  input  logic            mretM,
  input  logic            sretM,
  input  logic [XLEN-1:0] MSTATUS_REGW,
  input  logic [XLEN-1:0] MSTATUSH_REGW,
  input  logic [XLEN-1:0] SSTATUS_REGW,
  output logic            WriteMSTATUSM,
  output logic            WriteMSTATUSHM,
  output logic            WriteSSTATUSM,
  output logic [XLEN-1:0] CSRWriteValM,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
`ifdef STATUS_WRITE_READBACK_EN
  ,
  output logic [XLEN-1:0] rsp_newdata,
  output logic            rsp_legalized
`endif
);

`ifdef STATUS_WRITE_READBACK_EN
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, CHECK} state_t;
  logic [XLEN-1:0] wval_q;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
`endif

  state_t          state;
  logic [1:0]      op_q, sel_q, priv_q;
  logic [XLEN-1:0] operand_q;
  logic [XLEN-1:0] old_val, new_val;
  logic            legal, blocked, commit, do_write;
  logic            priv_m, priv_s_ok, priv_known;

  always_comb begin
    old_val = '0;
    case (sel_q)
      2'b00:   old_val = MSTATUS_REGW;
      2'b01:   old_val = MSTATUSH_REGW;
      2'b10:   old_val = SSTATUS_REGW;
      default: old_val = '0;
    endcase
  end

  always_comb begin
    priv_m     = (priv_q == 2'b11);
    priv_s_ok  = priv_m || ((priv_q == 2'b01) && (S_SUPPORTED != 0));
    priv_known = priv_s_ok || ((priv_q == 2'b00) && (U_SUPPORTED != 0));
    legal      = 1'b0;
    case (sel_q)
      2'b00:   legal = priv_m;
      2'b01:   legal = (XLEN != 64) && priv_m;
      2'b10:   legal = (S_SUPPORTED != 0) && priv_s_ok;
      default: legal = 1'b0;
    endcase
    legal = legal && priv_known;
  end

  always_comb begin
    new_val = operand_q;
    case (op_q)
      2'b00:   new_val = operand_q;
      2'b01:   new_val = old_val | operand_q;
      2'b10:   new_val = old_val & ~operand_q;
      default: new_val = old_val;
    endcase
  end

  // Strobes are combinational so a write can only coincide with a cycle that
  // has no stall and no higher-priority status update.
  assign blocked  = StallW | TrapM | mretM | sretM;
  assign commit   = (state == ISSUE) && legal && !blocked;
  assign do_write = commit && ((op_q == 2'b00) ||
                    (((op_q == 2'b01) || (op_q == 2'b10)) && (operand_q != '0)));

  assign WriteMSTATUSM  = do_write && (sel_q == 2'b00);
  assign WriteMSTATUSHM = do_write && (sel_q == 2'b01);
  assign WriteSSTATUSM  = do_write && (sel_q == 2'b10);
  assign CSRWriteValM   = do_write ? new_val : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      op_q      <= '0;
      sel_q     <= '0;
      priv_q    <= '0;
      operand_q <= '0;
`ifdef STATUS_WRITE_READBACK_EN
      wval_q        <= '0;
      rsp_newdata   <= '0;
      rsp_legalized <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            sel_q     <= req_sel;
            priv_q    <= PrivilegeModeW;
            operand_q <= req_operand;
            req_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!legal) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef STATUS_WRITE_READBACK_EN
            rsp_newdata   <= '0;
            rsp_legalized <= 1'b0;
`endif
          end else if (!blocked) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= old_val;
`ifdef STATUS_WRITE_READBACK_EN
            if (do_write) begin
              wval_q <= new_val;
              state  <= CHECK;
            end else begin
              rsp_newdata   <= old_val;
              rsp_legalized <= 1'b0;
              rsp_valid     <= 1'b1;
              state         <= RESP;
            end
`else
            rsp_valid <= 1'b1;
            state     <= RESP;
`endif
          end
        end
`ifdef STATUS_WRITE_READBACK_EN
        CHECK: begin
          rsp_newdata   <= old_val;
          rsp_legalized <= (old_val != wval_q);
          rsp_valid     <= 1'b1;
          state         <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
